// File: rtl/system_worker2_cpu_ocm_arb.sv
// rtl/system_worker2_cpu_ocm_arb.sv - two-master round-robin front-end for the worker2 CPU debug RAM
// Zero-fills the RAM after reset, then grants one Avalon-MM access per cycle with read latency 1.
module system_worker2_cpu_ocm_arb #(
   parameter int ADDR_W         = 7,
   parameter int DEPTH          = 128,
   parameter int DATA_W         = 32,
   parameter int BE_W           = 4,
   parameter bit CLEAR_ON_RESET = 1'b1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [ADDR_W-1:0] s1_address,
   input  logic [BE_W-1:0]   s1_byteenable,
   input  logic              s1_read,
   input  logic              s1_write,
   input  logic [DATA_W-1:0] s1_writedata,
   output logic              s1_waitrequest,
   output logic [DATA_W-1:0] s1_readdata,
   output logic              s1_readdatavalid,
   input  logic [ADDR_W-1:0] s2_address,
   input  logic [BE_W-1:0]   s2_byteenable,
   input  logic              s2_read,
   input  logic              s2_write,
   input  logic [DATA_W-1:0] s2_writedata,
   output logic              s2_waitrequest,
   output logic [DATA_W-1:0] s2_readdata,
   output logic              s2_readdatavalid,
   output logic [ADDR_W-1:0] ram_address,
   output logic [BE_W-1:0]   ram_byteenable,
   output logic              ram_chipselect,
   output logic              ram_write,
   output logic [DATA_W-1:0] ram_writedata,
   input  logic [DATA_W-1:0] ram_readdata,
   output logic              busy
);

   typedef enum logic {ST_CLEAR, ST_IDLE} state_t;

   localparam state_t            RESET_STATE = CLEAR_ON_RESET ? ST_CLEAR : ST_IDLE;
   localparam logic [ADDR_W-1:0] LAST_ADDR   = ADDR_W'(DEPTH - 1);

   state_t            state, state_nxt;
   logic [ADDR_W-1:0] clr_cnt, clr_cnt_nxt;
   logic              last_grant;      // 0 = s1 granted last, 1 = s2
   logic [1:0]        rd_pend;
   logic              s1_req, s2_req;
   logic              gnt1, gnt2;
   logic              s1_rd_acc, s2_rd_acc;

   assign s1_req = s1_read | s1_write;
   assign s2_req = s2_read | s2_write;

   // A simultaneous read+write is a write, so it never produces a response.
   assign s1_rd_acc = gnt1 & s1_read & ~s1_write;
   assign s2_rd_acc = gnt2 & s2_read & ~s2_write;

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= RESET_STATE;
         clr_cnt    <= '0;
         last_grant <= 1'b1;
         rd_pend    <= 2'b00;
      end else begin
         state   <= state_nxt;
         clr_cnt <= clr_cnt_nxt;
         if (gnt1 | gnt2)
            last_grant <= gnt2;
         rd_pend <= {s2_rd_acc, s1_rd_acc};
      end
   end

   always_comb begin
      state_nxt      = state;
      clr_cnt_nxt    = clr_cnt;
      gnt1           = 1'b0;
      gnt2           = 1'b0;
      busy           = 1'b0;
      ram_address    = '0;
      ram_byteenable = '0;
      ram_chipselect = 1'b0;
      ram_write      = 1'b0;
      ram_writedata  = '0;
      case (state)
         ST_CLEAR: begin
            busy           = 1'b1;
            ram_chipselect = 1'b1;
            ram_write      = 1'b1;
            ram_byteenable = '1;
            ram_address    = clr_cnt;
            if (clr_cnt == LAST_ADDR) begin
               state_nxt   = ST_IDLE;
               clr_cnt_nxt = '0;
            end else begin
               clr_cnt_nxt = clr_cnt + 1'b1;
            end
         end
         ST_IDLE: begin
            // On contention the master that did not win last time goes first.
            if (s1_req && (!s2_req || last_grant))
               gnt1 = 1'b1;
            else if (s2_req)
               gnt2 = 1'b1;
            if (gnt1) begin
               ram_chipselect = 1'b1;
               ram_write      = s1_write;
               ram_address    = s1_address;
               ram_byteenable = s1_byteenable;
               ram_writedata  = s1_writedata;
            end else if (gnt2) begin
               ram_chipselect = 1'b1;
               ram_write      = s2_write;
               ram_address    = s2_address;
               ram_byteenable = s2_byteenable;
               ram_writedata  = s2_writedata;
            end
         end
         default: state_nxt = RESET_STATE;
      endcase
   end

   assign s1_waitrequest = ~gnt1;
   assign s2_waitrequest = ~gnt2;

   // Gating with reset drops a response whose read was accepted just before reset.
   assign s1_readdatavalid = rd_pend[0] & ~reset;
   assign s2_readdatavalid = rd_pend[1] & ~reset;
   assign s1_readdata      = ram_readdata;
   assign s2_readdata      = ram_readdata;

endmodule

// File: tb/tb_system_worker2_cpu_ocm_arb.sv
// tb/tb_system_worker2_cpu_ocm_arb.sv - directed bench for the worker2 CPU debug RAM arbiter
// Includes a 128x32 RAM model with registered address and unregistered q.
module tb_system_worker2_cpu_ocm_arb;

   logic        clk;
   logic        reset;
   logic [6:0]  s1_address, s2_address;
   logic [3:0]  s1_byteenable, s2_byteenable;
   logic        s1_read, s1_write, s2_read, s2_write;
   logic [31:0] s1_writedata, s2_writedata;
   logic        s1_waitrequest, s2_waitrequest;
   logic [31:0] s1_readdata, s2_readdata;
   logic        s1_readdatavalid, s2_readdatavalid;
   logic [6:0]  ram_address;
   logic [3:0]  ram_byteenable;
   logic        ram_chipselect, ram_write;
   logic [31:0] ram_writedata, ram_readdata;
   logic        busy;

   logic [31:0] mem [0:127];
   logic [6:0]  ram_addr_q;
   logic        bd_en;
   logic [6:0]  bd_addr;
   logic [31:0] bd_data;

   int n_vec = 0;
   int n_err = 0;

   system_worker2_cpu_ocm_arb dut (
      .clk(clk), .reset(reset),
      .s1_address(s1_address), .s1_byteenable(s1_byteenable), .s1_read(s1_read),
      .s1_write(s1_write), .s1_writedata(s1_writedata), .s1_waitrequest(s1_waitrequest),
      .s1_readdata(s1_readdata), .s1_readdatavalid(s1_readdatavalid),
      .s2_address(s2_address), .s2_byteenable(s2_byteenable), .s2_read(s2_read),
      .s2_write(s2_write), .s2_writedata(s2_writedata), .s2_waitrequest(s2_waitrequest),
      .s2_readdata(s2_readdata), .s2_readdatavalid(s2_readdatavalid),
      .ram_address(ram_address), .ram_byteenable(ram_byteenable),
      .ram_chipselect(ram_chipselect), .ram_write(ram_write),
      .ram_writedata(ram_writedata), .ram_readdata(ram_readdata), .busy(busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Backdoor port lets the bench preload words without going through the DUT.
   always @(posedge clk) begin
      if (bd_en) begin
         mem[bd_addr] <= bd_data;
      end else if (ram_chipselect) begin
         if (ram_write)
            for (int b = 0; b < 4; b++)
               if (ram_byteenable[b]) mem[ram_address][8*b +: 8] <= ram_writedata[8*b +: 8];
         ram_addr_q <= ram_address;
      end
   end
   assign ram_readdata = mem[ram_addr_q];

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic preload(input logic [6:0] a, input logic [31:0] d);
      bd_en = 1'b1; bd_addr = a; bd_data = d;
      @(posedge clk); @(negedge clk);
      bd_en = 1'b0;
   endtask

   // Walks a sweep that starts at the current negedge; request inputs may be held meanwhile.
   task automatic check_sweep(input string tag);
      int n = 0;
      int bad = 0;
      int nz = 0;
      while (busy === 1'b1 && n < 300) begin
         if (ram_address !== n[6:0] || ram_chipselect !== 1'b1 || ram_write !== 1'b1 ||
             ram_writedata !== 32'h0 || ram_byteenable !== 4'hF || s1_waitrequest !== 1'b1 ||
             s2_waitrequest !== 1'b1 || s1_readdatavalid !== 1'b0 || s2_readdatavalid !== 1'b0)
            bad++;
         @(posedge clk); @(negedge clk);
         n++;
      end
      s1_read = 1'b0; s1_write = 1'b0; s2_read = 1'b0; s2_write = 1'b0;
      for (int i = 0; i < 128; i++) if (mem[i] !== 32'h0) nz++;
      chk({tag, "_len"}, n, 128);
      chk({tag, "_bad"}, bad, 0);
      chk({tag, "_zero"}, nz, 0);
   endtask

   initial begin
      reset = 1'b1; bd_en = 1'b0; bd_addr = '0; bd_data = '0;
      s1_address = '0; s1_byteenable = 4'hF; s1_read = 0; s1_write = 0; s1_writedata = '0;
      s2_address = '0; s2_byteenable = 4'hF; s2_read = 0; s2_write = 0; s2_writedata = '0;
      @(negedge clk);
      for (int i = 0; i < 128; i++) preload(i[6:0], 32'hA5A5_0000 | i);

      chk("rst_busy", busy, 1);
      chk("rst_wait1", s1_waitrequest, 1);
      chk("rst_wait2", s2_waitrequest, 1);
      chk("rst_rdv1", s1_readdatavalid, 0);
      chk("rst_rdv2", s2_readdatavalid, 0);
      reset = 1'b0;
      check_sweep("sweep0");

      // Contention right after reset: s1 first, then strict alternation.
      preload(7'd10, 32'h1111_0010);
      preload(7'd20, 32'h2222_0020);
      s1_read = 1; s1_address = 7'd10; s2_read = 1; s2_address = 7'd20;
      for (int k = 0; k <= 6; k++) begin
         if (k == 6) begin s1_read = 0; s2_read = 0; end
         #2;
         if (k < 6) begin
            chk("rr_wait1", s1_waitrequest, (k % 2 == 1));
            chk("rr_wait2", s2_waitrequest, (k % 2 == 0));
         end
         if (k > 0) begin
            chk("rr_rdv1", s1_readdatavalid, ((k - 1) % 2 == 0));
            chk("rr_rdv2", s2_readdatavalid, ((k - 1) % 2 == 1));
            chk("rr_data", s1_readdata, ((k - 1) % 2 == 0) ? 32'h1111_0010 : 32'h2222_0020);
         end
         @(posedge clk); @(negedge clk);
      end

      // Partial-byte write then read back.
      preload(7'd5, 32'hFFFF_FFFF);
      s1_write = 1; s1_address = 7'd5; s1_byteenable = 4'b0011; s1_writedata = 32'hAABB_CCDD;
      #2 chk("wr_wait", s1_waitrequest, 0);
      @(posedge clk); @(negedge clk);
      s1_write = 0; s1_byteenable = 4'hF; s1_read = 1;
      #2 chk("rd_wait", s1_waitrequest, 0);
      chk("wr_no_rdv", s1_readdatavalid, 0);
      @(posedge clk); @(negedge clk);
      s1_read = 0;
      #2 chk("rd_rdv", s1_readdatavalid, 1);
      chk("rd_data", s1_readdata, 32'hFFFF_CCDD);
      chk("rd_rdv2", s2_readdatavalid, 0);
      @(posedge clk); @(negedge clk);

      // Back-to-back reads from s1 alone.
      for (int i = 0; i < 8; i++) preload(i[6:0], i * 3);
      for (int i = 0; i <= 8; i++) begin
         if (i < 8) begin s1_read = 1; s1_address = i[6:0]; end
         else s1_read = 0;
         #2;
         if (i < 8) chk("b2b_wait", s1_waitrequest, 0);
         if (i > 0) begin
            chk("b2b_rdv", s1_readdatavalid, 1);
            chk("b2b_data", s1_readdata, (i - 1) * 3);
         end
         @(posedge clk); @(negedge clk);
      end
      #2 chk("b2b_end", s1_readdatavalid, 0);
      @(negedge clk);

      // s2 read accepted, reset on the very next cycle.
      s2_read = 1; s2_address = 7'd7;
      #2 chk("rr6_wait2", s2_waitrequest, 0);
      @(posedge clk); @(negedge clk);
      s2_read = 0; reset = 1;
      #2 chk("rr6_rdv_rst", s2_readdatavalid, 0);
      @(posedge clk); @(negedge clk);
      chk("rr6_rdv_after", s2_readdatavalid, 0);
      reset = 0;
      begin
         int bad = 0;
         for (int j = 0; j < 50; j++) begin
            if (s2_readdatavalid !== 1'b0 || busy !== 1'b1) bad++;
            @(posedge clk); @(negedge clk);
         end
         chk("rr6_stale", bad, 0);
      end

      // Reset mid-sweep while both masters request: sweep restarts at 0.
      chk("mid_addr", ram_address, 50);
      s1_read = 1; s2_write = 1; reset = 1;
      @(posedge clk); @(negedge clk);
      reset = 0;
      check_sweep("sweep_mid");

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
